// File: rtl/pong_pkg.sv
// Shared state encodings, screen geometry and helper functions for the pong game logic.
package pong_pkg;

  typedef enum logic [1:0] {
    QI      = 2'b00,
    QGAME_1 = 2'b01,
    QGAME_2 = 2'b10,
    QDONE   = 2'b11
  } state_e;

  localparam logic [9:0] V_ACTIVE     = 10'd480;
  localparam logic [9:0] H_ACTIVE     = 10'd640;
  localparam logic [9:0] PADDLE_HALF  = 10'd20;
  localparam logic [9:0] PADDLE_STEP  = 10'd4;
  localparam logic [9:0] BALL_HALF    = 10'd4;
  localparam logic [9:0] BALL_STEP    = 10'd2;
  localparam logic [9:0] P1_FACE      = 10'd40;
  localparam logic [9:0] P2_FACE      = 10'd600;
  localparam logic [3:0] WIN_SCORE    = 4'd10;
  localparam logic [5:0] SERVE_FRAMES = 6'd60;

  localparam logic [9:0] X_CENTRE = 10'd320;
  localparam logic [9:0] Y_CENTRE = 10'd240;

  localparam logic [9:0] PADDLE_MIN = PADDLE_HALF;
  localparam logic [9:0] PADDLE_MAX = V_ACTIVE - 10'd1 - PADDLE_HALF;

  // Ball travel limits: the *_LIM values are the pre-move positions that trigger a wall event.
  localparam logic [9:0] BALL_Y_MIN       = BALL_HALF;
  localparam logic [9:0] BALL_Y_MAX       = V_ACTIVE - 10'd1 - BALL_HALF;
  localparam logic [9:0] BALL_Y_TOP_LIM   = BALL_HALF + BALL_STEP;
  localparam logic [9:0] BALL_Y_BOT_LIM   = V_ACTIVE - 10'd1 - BALL_HALF - BALL_STEP;
  localparam logic [9:0] BALL_X_LEFT_LIM  = BALL_HALF + BALL_STEP;
  localparam logic [9:0] BALL_X_RIGHT_LIM = H_ACTIVE - 10'd1 - BALL_HALF - BALL_STEP;
  localparam logic [9:0] FACE_L           = P1_FACE + BALL_HALF;
  localparam logic [9:0] FACE_R           = P2_FACE - BALL_HALF;

  // Vertical overlap of ball and paddle, widened to 11 bits so neither sum can wrap.
  function automatic logic paddle_hit(input logic [9:0] pad_y, input logic [9:0] ball_y);
    logic [10:0] reach;
    reach = {1'b0, PADDLE_HALF} + {1'b0, BALL_HALF};
    return ({1'b0, pad_y} <= ({1'b0, ball_y} + reach)) &&
           ({1'b0, ball_y} <= ({1'b0, pad_y} + reach));
  endfunction

  function automatic logic [3:0] score_inc(input logic [3:0] score);
    return (score == 4'd15) ? 4'd15 : score + 4'd1;
  endfunction

endpackage

// File: rtl/pong_game_ctrl_paddle.sv
// One paddle's centre-line register: saturating up/down steps when enabled, recentre on clear.
module paddle_ctrl
  import pong_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       clr,
  input  logic       up,
  input  logic       dn,
  output logic [9:0] y_q
);

  logic [9:0] y_d;

  // Next paddle position; pressing both buttons cancels out.
  always_comb begin
    y_d = y_q;
    if (clr) begin
      y_d = Y_CENTRE;
    end else if (en && up && !dn) begin
      y_d = (y_q <= (PADDLE_MIN + PADDLE_STEP)) ? PADDLE_MIN : (y_q - PADDLE_STEP);
    end else if (en && dn && !up) begin
      y_d = (y_q >= (PADDLE_MAX - PADDLE_STEP)) ? PADDLE_MAX : (y_q + PADDLE_STEP);
    end else begin
      y_d = y_q;
    end
  end

  // Paddle position register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q <= Y_CENTRE;
    end else begin
      y_q <= y_d;
    end
  end

endmodule

// File: rtl/pong_game_ctrl.sv
// Per-frame pong game logic: paddles, ball motion, scoring and game state, all registered.
module pong_game_ctrl
  import pong_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       start,
  input  logic       p1_up,
  input  logic       p1_dn,
  input  logic       p2_up,
  input  logic       p2_dn,
  output logic [9:0] paddle1_y,
  output logic [9:0] paddle2_y,
  output logic [9:0] ball_x,
  output logic [9:0] ball_y,
  output logic [3:0] p1_score,
  output logic [3:0] p2_score,
  output logic [1:0] state,
  output logic       point_pulse
);

  state_e     state_q, state_d;
  logic [5:0] serve_cnt_q, serve_cnt_d;
  logic [9:0] ball_x_q, ball_x_d;
  logic [9:0] ball_y_q, ball_y_d;
  logic       dx_q, dx_d;           // 1 = moving right
  logic       dy_q, dy_d;           // 1 = moving down
  logic [3:0] p1_score_q, p1_score_d;
  logic [3:0] p2_score_q, p2_score_d;
  logic       point_pulse_q, point_pulse_d;
  logic       paddle_en_s, paddle_clr_s;
  logic       p1_point_s, p2_point_s;

  assign paddle_en_s  = tick && ((state_q == QGAME_1) || (state_q == QGAME_2));
  assign paddle_clr_s = tick && (state_q == QDONE) && !start;

  paddle_ctrl u_paddle1 (
    .clk   (clk),
    .rst_n (reset),
    .en    (paddle_en_s),
    .clr   (paddle_clr_s),
    .up    (p1_up),
    .dn    (p1_dn),
    .y_q   (paddle1_y)
  );

  paddle_ctrl u_paddle2 (
    .clk   (clk),
    .rst_n (reset),
    .en    (paddle_en_s),
    .clr   (paddle_clr_s),
    .up    (p2_up),
    .dn    (p2_dn),
    .y_q   (paddle2_y)
  );

  // Game FSM with ball and score update; wall/paddle checks use the pre-tick positions.
  always_comb begin
    state_d       = state_q;
    serve_cnt_d   = serve_cnt_q;
    ball_x_d      = ball_x_q;
    ball_y_d      = ball_y_q;
    dx_d          = dx_q;
    dy_d          = dy_q;
    p1_score_d    = p1_score_q;
    p2_score_d    = p2_score_q;
    point_pulse_d = 1'b0;
    p1_point_s    = 1'b0;
    p2_point_s    = 1'b0;
    if (tick) begin
      case (state_q)
        QI: begin
          if (start) begin
            state_d     = QGAME_1;
            serve_cnt_d = SERVE_FRAMES;
          end else begin
            state_d = QI;
          end
        end
        QGAME_1: begin
          ball_x_d    = X_CENTRE;
          ball_y_d    = Y_CENTRE;
          serve_cnt_d = serve_cnt_q - 6'd1;
          if (serve_cnt_q == 6'd1) begin
            state_d = QGAME_2;
          end else begin
            state_d = QGAME_1;
          end
        end
        QGAME_2: begin
          if (!dy_q) begin
            if (ball_y_q <= BALL_Y_TOP_LIM) begin
              ball_y_d = BALL_Y_MIN;
              dy_d     = 1'b1;
            end else begin
              ball_y_d = ball_y_q - BALL_STEP;
            end
          end else begin
            if (ball_y_q >= BALL_Y_BOT_LIM) begin
              ball_y_d = BALL_Y_MAX;
              dy_d     = 1'b0;
            end else begin
              ball_y_d = ball_y_q + BALL_STEP;
            end
          end
          if (!dx_q) begin
            if (ball_x_q <= BALL_X_LEFT_LIM) begin
              p2_point_s = 1'b1;
            end else if ((ball_x_q >= FACE_L) && ((ball_x_q - BALL_STEP) <= FACE_L)) begin
              if (paddle_hit(paddle1_y, ball_y_q)) begin
                ball_x_d = FACE_L;
                dx_d     = 1'b1;
              end else begin
                ball_x_d = ball_x_q - BALL_STEP;
              end
            end else begin
              ball_x_d = ball_x_q - BALL_STEP;
            end
          end else begin
            if (ball_x_q >= BALL_X_RIGHT_LIM) begin
              p1_point_s = 1'b1;
            end else if ((ball_x_q <= FACE_R) && ((ball_x_q + BALL_STEP) >= FACE_R)) begin
              if (paddle_hit(paddle2_y, ball_y_q)) begin
                ball_x_d = FACE_R;
                dx_d     = 1'b0;
              end else begin
                ball_x_d = ball_x_q + BALL_STEP;
              end
            end else begin
              ball_x_d = ball_x_q + BALL_STEP;
            end
          end
          // A point recentres the ball and serves it toward the player who conceded.
          if (p1_point_s || p2_point_s) begin
            point_pulse_d = 1'b1;
            ball_x_d      = X_CENTRE;
            ball_y_d      = Y_CENTRE;
            if (p1_point_s) begin
              p1_score_d = score_inc(p1_score_q);
              dx_d       = 1'b1;
            end else begin
              p2_score_d = score_inc(p2_score_q);
              dx_d       = 1'b0;
            end
            if ((p1_score_d == WIN_SCORE) || (p2_score_d == WIN_SCORE)) begin
              state_d = QDONE;
            end else begin
              state_d     = QGAME_1;
              serve_cnt_d = SERVE_FRAMES;
            end
          end else begin
            state_d = QGAME_2;
          end
        end
        QDONE: begin
          if (!start) begin
            state_d    = QI;
            p1_score_d = 4'd0;
            p2_score_d = 4'd0;
            ball_x_d   = X_CENTRE;
            ball_y_d   = Y_CENTRE;
            dx_d       = 1'b1;
            dy_d       = 1'b1;
          end else begin
            state_d = QDONE;
          end
        end
        default: begin
          state_d = QI;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Game state registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= QI;
      serve_cnt_q   <= 6'd0;
      ball_x_q      <= X_CENTRE;
      ball_y_q      <= Y_CENTRE;
      dx_q          <= 1'b1;
      dy_q          <= 1'b1;
      p1_score_q    <= 4'd0;
      p2_score_q    <= 4'd0;
      point_pulse_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      serve_cnt_q   <= serve_cnt_d;
      ball_x_q      <= ball_x_d;
      ball_y_q      <= ball_y_d;
      dx_q          <= dx_d;
      dy_q          <= dy_d;
      p1_score_q    <= p1_score_d;
      p2_score_q    <= p2_score_d;
      point_pulse_q <= point_pulse_d;
    end
  end

  assign ball_x      = ball_x_q;
  assign ball_y      = ball_y_q;
  assign p1_score    = p1_score_q;
  assign p2_score    = p2_score_q;
  assign state       = state_q;
  assign point_pulse = point_pulse_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Scoreboard bench for pong_game_ctrl: a frame-level game model queues expected outputs per tick.
module tb_pong_game_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tick = 1'b0;
  logic       start = 1'b0;
  logic       p1_up = 1'b0, p1_dn = 1'b0, p2_up = 1'b0, p2_dn = 1'b0;
  logic [9:0] paddle1_y, paddle2_y, ball_x, ball_y;
  logic [3:0] p1_score, p2_score;
  logic [1:0] state;
  logic       point_pulse;

  pong_game_ctrl dut (
    .clk(clk), .reset(reset), .tick(tick), .start(start),
    .p1_up(p1_up), .p1_dn(p1_dn), .p2_up(p2_up), .p2_dn(p2_dn),
    .paddle1_y(paddle1_y), .paddle2_y(paddle2_y), .ball_x(ball_x), .ball_y(ball_y),
    .p1_score(p1_score), .p2_score(p2_score), .state(state), .point_pulse(point_pulse)
  );

  always #5 clk = ~clk;

  typedef struct { int p1y; int p2y; int bx; int by; int s1; int s2; int st; int pp; } exp_t;
  exp_t sb[$];
  int n_vec = 0;
  int n_err = 0;

  // Frame-level game model (dx: 1 right, dy: 1 down).
  int m_p1y, m_p2y, m_bx, m_by, m_dx, m_dy, m_s1, m_s2, m_st, m_cnt, m_pp;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_p1y = 240; m_p2y = 240; m_bx = 320; m_by = 240; m_dx = 1; m_dy = 1;
    m_s1 = 0; m_s2 = 0; m_st = 0; m_cnt = 0; m_pp = 0;
  endtask

  function automatic int pad_next(int y, bit u, bit d);
    if (u && !d) return (y - 4 < 20) ? 20 : y - 4;
    if (d && !u) return (y + 4 > 459) ? 459 : y + 4;
    return y;
  endfunction

  function automatic bit hit(int py, int by);
    return (py - by <= 24) && (by - py <= 24);
  endfunction

  task automatic model_step(input bit s, input bit u1, input bit d1, input bit u2, input bit d2);
    int nbx, nby, ndx, ndy;
    bit p1pt, p2pt;
    m_pp = 0;
    case (m_st)
      0: if (s) begin m_st = 1; m_cnt = 60; end
      1: begin
        m_p1y = pad_next(m_p1y, u1, d1);
        m_p2y = pad_next(m_p2y, u2, d2);
        m_bx = 320; m_by = 240;
        m_cnt = m_cnt - 1;
        if (m_cnt == 0) m_st = 2;
      end
      2: begin
        nbx = m_bx; nby = m_by; ndx = m_dx; ndy = m_dy; p1pt = 0; p2pt = 0;
        if (m_dy == 0) begin
          if (m_by <= 6) begin nby = 4; ndy = 1; end else nby = m_by - 2;
        end else begin
          if (m_by >= 473) begin nby = 475; ndy = 0; end else nby = m_by + 2;
        end
        if (m_dx == 0) begin
          if (m_bx <= 6) p2pt = 1;
          else if (m_bx >= 44 && m_bx - 2 <= 44 && hit(m_p1y, m_by)) begin nbx = 44; ndx = 1; end
          else nbx = m_bx - 2;
        end else begin
          if (m_bx >= 633) p1pt = 1;
          else if (m_bx <= 596 && m_bx + 2 >= 596 && hit(m_p2y, m_by)) begin nbx = 596; ndx = 0; end
          else nbx = m_bx + 2;
        end
        m_p1y = pad_next(m_p1y, u1, d1);
        m_p2y = pad_next(m_p2y, u2, d2);
        m_bx = nbx; m_by = nby; m_dx = ndx; m_dy = ndy;
        if (p1pt || p2pt) begin
          m_pp = 1; m_bx = 320; m_by = 240;
          if (p2pt) begin m_s2 = (m_s2 < 15) ? m_s2 + 1 : 15; m_dx = 0; end
          else begin m_s1 = (m_s1 < 15) ? m_s1 + 1 : 15; m_dx = 1; end
          if (m_s1 == 10 || m_s2 == 10) m_st = 3;
          else begin m_st = 1; m_cnt = 60; end
        end
      end
      default: if (!s) m_reset();
    endcase
  endtask

  task automatic do_tick(input bit s, input bit u1, input bit d1, input bit u2, input bit d2);
    @(negedge clk);
    start = s; p1_up = u1; p1_dn = d1; p2_up = u2; p2_dn = d2;
    tick = 1'b1;
    model_step(s, u1, d1, u2, d2);
    sb.push_back('{m_p1y, m_p2y, m_bx, m_by, m_s1, m_s2, m_st, m_pp});
    @(negedge clk);
    tick = 1'b0;
    @(negedge clk);
  endtask

  task automatic chk_reset_vals();
    chk("rst_paddle1", paddle1_y, 240); chk("rst_paddle2", paddle2_y, 240);
    chk("rst_ball_x", ball_x, 320);     chk("rst_ball_y", ball_y, 240);
    chk("rst_p1_score", p1_score, 0);   chk("rst_p2_score", p2_score, 0);
    chk("rst_state", state, 0);         chk("rst_pulse", point_pulse, 0);
  endtask

  // Monitor: one clk after every tick, pop the expected frame and compare; then pulse must clear.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      if (tick === 1'b1) begin
        #1;
        if (sb.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL sb_empty: output frame with no expected entry at %0t", $time);
        end else begin
          e = sb.pop_front();
          chk("paddle1_y", paddle1_y, e.p1y); chk("paddle2_y", paddle2_y, e.p2y);
          chk("ball_x", ball_x, e.bx);        chk("ball_y", ball_y, e.by);
          chk("p1_score", p1_score, e.s1);    chk("p2_score", p2_score, e.s2);
          chk("state", state, e.st);          chk("point_pulse", point_pulse, e.pp);
        end
        @(posedge clk);
        #1;
        chk("pulse_clear", point_pulse, 0);
      end
    end
  end

  initial begin
    bit u2, d2;
    int r;
    m_reset();
    #1 reset = 1'b0;
    #2 chk_reset_vals();
    repeat (2) @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 5; i++) do_tick(0, 0, 0, 0, 0);
    chk("idle_state", state, 0);

    do_tick(1, 0, 0, 0, 0);
    chk("serve_state", state, 1);
    // Serve: p1 climbs to the top stop; p2 steps down 50 times, then both buttons held.
    for (int i = 1; i <= 60; i++) begin
      do_tick(1, 1, 0, (i > 50), 1);
      if (i == 54) chk("p1_sat_24", paddle1_y, 24);
      if (i == 55) chk("p1_sat_20", paddle1_y, 20);
      if (i == 60) chk("p1_sat_hold", paddle1_y, 20);
      if (i == 50) chk("p2_down_440", paddle2_y, 440);
      if (i == 60) chk("p2_both_hold", paddle2_y, 440);
      if (i == 59) chk("serve_end_st", state, 1);
      if (i == 60) chk("rally_state", state, 2);
    end

    // Rally phase: first rally is hand-traced, after that p2 tracks the ball and p1 stands still.
    r = 0;
    while (m_st != 3 && r < 6000) begin
      r++;
      u2 = (r >= 415) && (m_by < m_p2y);
      d2 = (r >= 415) && (m_by > m_p2y);
      do_tick(!(r >= 200 && r < 250), 0, (r <= 30), u2, d2);
      case (r)
        1:   begin chk("first_ball_x", ball_x, 322); chk("first_ball_y", ball_y, 242); end
        30:  chk("p1_down_140", paddle1_y, 140);
        118: chk("bottom_wall_y", ball_y, 475);
        119: chk("bottom_bounce_y", ball_y, 473);
        138: chk("p2_hit_x", ball_x, 596);
        139: chk("p2_hit_ret_x", ball_x, 594);
        353: chk("top_y_5", ball_y, 5);
        354: chk("top_wall_y", ball_y, 4);
        355: chk("top_bounce_y", ball_y, 6);
        414: chk("p1_hit_x", ball_x, 44);
        415: chk("p1_hit_ret_x", ball_x, 46);
        default: ;
      endcase
    end
    chk("game_over_state", state, 3);
    chk("winner_p2", p2_score, 10);
    chk("loser_p1", p1_score, 0);

    for (int i = 0; i < 3; i++) do_tick(1, 1, 0, 0, 1);
    chk("done_frozen_x", ball_x, m_bx);
    chk("done_frozen_p1", paddle1_y, m_p1y);
    do_tick(0, 0, 0, 0, 0);
    chk("done_to_idle", state, 0);
    chk("idle_p1_score", p1_score, 0);
    chk("idle_p2_score", p2_score, 0);

    // New game, then an asynchronous reset in the middle of the rally.
    do_tick(1, 0, 0, 0, 0);
    for (int i = 0; i < 70; i++) do_tick(1, 0, 1, 1, 0);
    chk("pre_abort_state", state, 2);
    #2 reset = 1'b0;
    #1 chk_reset_vals();
    m_reset();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 5; i++) do_tick(0, 0, 0, 0, 0);
    chk("post_reset_idle", state, 0);

    repeat (4) @(negedge clk);
    if (sb.size() != 0) begin
      n_vec++; n_err++;
      $display("FAIL sb_leftover: %0d expected frames never presented", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pong_game_ctrl.md
Name: pong_game_ctrl

Overview:
Game-logic stage directly upstream of the VGA renderer. Once per video frame it updates both paddle positions, the ball position and direction, the scores and the game state. Its outputs are registered and held stable for a full frame, and the pixel stage reads them directly. The score and state outputs also drive the LED and SSD logic.

Parameters:
V_ACTIVE, 480, visible lines
H_ACTIVE, 640, visible pixels per line
PADDLE_HALF, 20, paddle half-height in lines
PADDLE_STEP, 4, paddle move per frame
BALL_HALF, 4, ball half-size
BALL_STEP, 2, ball move per frame on each axis
P1_FACE, 40, x of left paddle's inner face
P2_FACE, 600, x of right paddle's inner face
WIN_SCORE, 10, score that ends the game
SERVE_FRAMES, 60, frames ball is parked before a rally

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
tick  in  1  one-clk pulse per frame (start of vertical blank)
start  in  1  start switch (level)
p1_up, p1_dn, p2_up, p2_dn  in  1 each  debounced button levels
paddle1_y, paddle2_y  out  10  paddle centre line
ball_x, ball_y  out  10  ball centre
p1_score, p2_score  out  4  scores
state  out  2  QI=00, QGAME_1=01 (serve), QGAME_2=10 (rally), QDONE=11
point_pulse  out  1  one-clk pulse when a point is scored

Behaviour:
- Reset (reset=0, asynchronous) sets every output and internal register as follows:
  - paddles 240; ball (320,240); dx=right, dy=down; scores 0
  - state QI; serve counter 0; point_pulse 0
- Registers change only on clk edges where tick=1. The one exception is point_pulse, which clears on the next clk. All results are visible 1 clk after tick.
- QI:
  - Paddles, ball and scores hold reset values.
  - tick with start=1 → QGAME_1, serve counter loaded with SERVE_FRAMES.
- QGAME_1:
  - Ball parked at (320,240); paddles move.
  - Each tick decrements the counter. A tick that sees counter==1 → QGAME_2 and the counter reaches 0.
- QGAME_2:
  - Paddles move and ball moves.
  - Paddle/wall/hit checks use current (pre-tick) positions.
- QDONE:
  - All positions and scores frozen.
  - tick with start=0 → QI, with scores cleared.
- Paddle rule (QGAME_1/2 only):
  - up only: y -= STEP, saturating at PADDLE_HALF.
  - down only: y += STEP, saturating at V_ACTIVE-1-PADDLE_HALF.
  - Both or neither pressed: hold.
- Ball vertical:
  - Moving up and y <= BALL_HALF+BALL_STEP → y=BALL_HALF, dy=down.
  - Moving down and y >= V_ACTIVE-1-BALL_HALF-BALL_STEP → y=V_ACTIVE-1-BALL_HALF, dy=up.
  - Otherwise y ± BALL_STEP.
- Ball horizontal, left side (L = P1_FACE+BALL_HALF), moving left:
  - Face crossing when x >= L and x-BALL_STEP <= L.
  - Hit when paddle1_y <= y+PADDLE_HALF+BALL_HALF and y <= paddle1_y+PADDLE_HALF+BALL_HALF. Use 11-bit intermediates; no subtraction underflow.
  - Hit → x=L, dx=right.
  - Miss → x -= BALL_STEP, no further face check.
- Right side mirrored, with R = P2_FACE-BALL_HALF.
- Scoring:
  - Moving left and x <= BALL_HALF+BALL_STEP → point to P2.
  - Moving right and x >= H_ACTIVE-1-BALL_HALF-BALL_STEP → point to P1.
- On a point:
  - Scorer's score +1, saturating at 15; point_pulse=1.
  - Ball recentred to (320,240); dx points toward the player who conceded; dy kept.
  - If new score == WIN_SCORE → QDONE, else → QGAME_1 with counter reloaded.
- At most one point per tick. Vertical and horizontal updates in the same tick are independent.
- start dropping during QGAME_1/2 has no effect; only reset aborts a game.

Decomposition:
- Package pong_pkg: state encodings (QI, QGAME_1, QGAME_2, QDONE), screen constants, centre coordinates.
- Sub-module paddle_ctrl: one paddle's saturating position register with enable. Instantiated twice.
- Ball, score and FSM stay in the top module.

Test Plan:
- Reset and idle: assert reset=0 mid-rally → all outputs at reset values immediately (no clk). Release, 5 ticks with start=0 → state stays 00.
- Serve: start=1, tick → state 01. After 60 more ticks → state 10. Next tick → ball_x 322, ball_y 242.
- Paddle saturation: hold p1_up for 60 ticks from 240 → 236, 232, …, reaches 20 after 55 ticks, then stays 20.
  - p2_up+p2_dn together → paddle2_y unchanged.
- Top wall: ball moving up at y=10 → 8, 6, then 4 with dy=down, then 6.
- Left paddle:
  - paddle1_y=240, ball moving left at x=46, y=250 → x=44, dx=right.
  - Same with y=300 → miss: x goes 44, 42, … and at x <= 6 → p2_score+1, point_pulse for 1 clk, state 01, ball (320,240), dx=left.
- Win: p2_score=9, P2 scores → p2_score=10, state 11, positions frozen. start=0 + tick → state 00, scores 0.
